// File: rtl/sdram_pkg.sv
// Shared definitions for the SDRAM controller: arbiter states,
// SDRAM command encodings {cs_n,ras_n,cas_n,we_n} and bus field widths.
package sdram_pkg;

   localparam int CMD_W  = 4;
   localparam int BA_W   = 2;
   localparam int ADDR_W = 13;
   localparam int BUS_W  = CMD_W + BA_W + ADDR_W;

   typedef enum logic [2:0] {
      INIT  = 3'd0,
      ARBIT = 3'd1,
      AREF  = 3'd2,
      WRITE = 3'd3,
      READ  = 3'd4
   } state_t;

   localparam logic [CMD_W-1:0] CMD_NOP  = 4'b0111;
   localparam logic [CMD_W-1:0] CMD_PRE  = 4'b0010;
   localparam logic [CMD_W-1:0] CMD_AREF = 4'b0001;
   localparam logic [CMD_W-1:0] CMD_ACT  = 4'b0011;
   localparam logic [CMD_W-1:0] CMD_WR   = 4'b0100;
   localparam logic [CMD_W-1:0] CMD_RD   = 4'b0101;
   localparam logic [CMD_W-1:0] CMD_MRS  = 4'b0000;

   // Idle bus value driven while the arbiter owns the pins
   localparam logic [BUS_W-1:0] BUS_NOP = {CMD_NOP, {BA_W{1'b0}}, {ADDR_W{1'b0}}};

endpackage

// File: rtl/sdram_ref_timer.sv
// Periodic refresh request generator. Counts while run is high, raises
// aref_pend at each terminal count and flags aref_miss if a new interval
// elapses while the previous request is still outstanding.
module sdram_ref_timer
   import sdram_pkg::*;
#(
   parameter int REF_CYCLES = 390,
   parameter int CNT_W      = 10
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   input  logic ack,
   output logic aref_pend,
   output logic aref_miss
);

   localparam logic [CNT_W-1:0] TERM_CNT = CNT_W'(REF_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pend_q, pend_d;
   logic             miss_q, miss_d;
   logic             term;

   // Counter wrap, request set-over-clear and sticky miss detection
   always_comb begin
      term   = run && (cnt_q == TERM_CNT);
      cnt_d  = cnt_q;
      pend_d = pend_q;
      miss_d = miss_q;
      if (!run) begin
         cnt_d = '0;
      end else if (term) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
      if (term) begin
         pend_d = 1'b1;
      end else if (ack) begin
         pend_d = 1'b0;
      end
      if (term && pend_q) begin
         miss_d = 1'b1;
      end
   end

   // Timer state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         pend_q <= 1'b0;
         miss_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         pend_q <= pend_d;
         miss_q <= miss_d;
      end
   end

   assign aref_pend = pend_q;
   assign aref_miss = miss_q;

endmodule

// File: rtl/sdram_arbit.sv
// SDRAM bus arbiter: gives the command/address pins to the init sequencer
// until init completes, then to refresh, write or read engines by fixed
// priority, one burst at a time with no preemption.
module sdram_arbit
   import sdram_pkg::*;
#(
   parameter int REF_CYCLES = 390,
   parameter int CNT_W      = 10
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              init_end,
   input  logic [BUS_W-1:0]  init_bus,
   input  logic [BUS_W-1:0]  aref_bus,
   input  logic              aref_end,
   input  logic [BUS_W-1:0]  wr_bus,
   input  logic              wr_end,
   input  logic [BUS_W-1:0]  rd_bus,
   input  logic              rd_end,
   input  logic              wr_trig,
   input  logic              rd_trig,
   output logic              aref_en,
   output logic              wr_en,
   output logic              rd_en,
   output logic [CMD_W-1:0]  sdram_cmd,
   output logic [BA_W-1:0]   sdram_ba,
   output logic [ADDR_W-1:0] sdram_addr,
   output logic              busy,
   output logic              aref_miss
);

   state_t           state_q, state_d;
   logic             wr_pend_q, wr_pend_d;
   logic             rd_pend_q, rd_pend_d;
   logic             aref_pend;
   logic             aref_ack;
   logic             timer_run;
   logic [BUS_W-1:0] bus_sel;

   assign timer_run = (state_q != INIT);
   assign aref_ack  = (state_q == ARBIT) && aref_pend;

   sdram_ref_timer #(
      .REF_CYCLES (REF_CYCLES),
      .CNT_W      (CNT_W)
   ) u_ref_timer (
      .clk       (clk),
      .rst_n     (rst_n),
      .run       (timer_run),
      .ack       (aref_ack),
      .aref_pend (aref_pend),
      .aref_miss (aref_miss)
   );

   // Next-state selection: fixed priority refresh > write > read in ARBIT
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         INIT:  if (init_end) state_d = ARBIT;
         ARBIT: begin
            if (aref_pend)      state_d = AREF;
            else if (wr_pend_q) state_d = WRITE;
            else if (rd_pend_q) state_d = READ;
         end
         AREF:  if (aref_end) state_d = ARBIT;
         WRITE: if (wr_end)   state_d = ARBIT;
         READ:  if (rd_end)   state_d = ARBIT;
         default: state_d = INIT;
      endcase
   end

   // Request latches: set wins over the grant-time clear, dropped in INIT
   always_comb begin
      wr_pend_d = wr_pend_q;
      rd_pend_d = rd_pend_q;
      if (state_q == INIT) begin
         wr_pend_d = 1'b0;
         rd_pend_d = 1'b0;
      end else begin
         if (wr_trig) begin
            wr_pend_d = 1'b1;
         end else if ((state_q == ARBIT) && (state_d == WRITE)) begin
            wr_pend_d = 1'b0;
         end
         if (rd_trig) begin
            rd_pend_d = 1'b1;
         end else if ((state_q == ARBIT) && (state_d == READ)) begin
            rd_pend_d = 1'b0;
         end
      end
   end

   // State and request registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= INIT;
         wr_pend_q <= 1'b0;
         rd_pend_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_pend_q <= wr_pend_d;
         rd_pend_q <= rd_pend_d;
      end
   end

   // Grants and pin mux decoded from the state register alone
   always_comb begin
      aref_en = 1'b0;
      wr_en   = 1'b0;
      rd_en   = 1'b0;
      bus_sel = BUS_NOP;
      unique case (state_q)
         INIT:  bus_sel = init_bus;
         ARBIT: bus_sel = BUS_NOP;
         AREF:  begin aref_en = 1'b1; bus_sel = aref_bus; end
         WRITE: begin wr_en   = 1'b1; bus_sel = wr_bus;   end
         READ:  begin rd_en   = 1'b1; bus_sel = rd_bus;   end
         default: bus_sel = init_bus;
      endcase
   end

   assign busy = (state_q != ARBIT);
   assign {sdram_cmd, sdram_ba, sdram_addr} = bus_sel;

endmodule

// File: tb/tb_sdram_arbit.sv
// Directed bench for sdram_arbit with a short refresh interval.
module tb_sdram_arbit;

   localparam logic [18:0] INIT_BUS = 19'h1ABCD;
   localparam logic [18:0] AREF_BUS = 19'h08642;
   localparam logic [18:0] WR_BUS   = 19'h23456;
   localparam logic [18:0] RD_BUS   = 19'h51357;
   localparam logic [18:0] NOP_BUS  = 19'h38000;

   // {aref_en, wr_en, rd_en, busy}
   localparam logic [3:0] G_INIT  = 4'b0001;
   localparam logic [3:0] G_ARBIT = 4'b0000;
   localparam logic [3:0] G_AREF  = 4'b1001;
   localparam logic [3:0] G_WRITE = 4'b0101;
   localparam logic [3:0] G_READ  = 4'b0011;

   // pulse selector bits for applyStimulus
   localparam logic [4:0] P_WTRIG = 5'b10000;
   localparam logic [4:0] P_RTRIG = 5'b01000;
   localparam logic [4:0] P_WEND  = 5'b00100;
   localparam logic [4:0] P_REND  = 5'b00010;
   localparam logic [4:0] P_AEND  = 5'b00001;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        init_end = 1'b0;
   logic [18:0] init_bus = INIT_BUS;
   logic [18:0] aref_bus = AREF_BUS;
   logic [18:0] wr_bus = WR_BUS;
   logic [18:0] rd_bus = RD_BUS;
   logic        aref_end = 1'b0;
   logic        wr_end = 1'b0;
   logic        rd_end = 1'b0;
   logic        wr_trig = 1'b0;
   logic        rd_trig = 1'b0;
   logic        aref_en, wr_en, rd_en, busy, aref_miss;
   logic [3:0]  sdram_cmd;
   logic [1:0]  sdram_ba;
   logic [12:0] sdram_addr;

   int test_count = 0;
   int fail_count = 0;

   sdram_arbit #(
      .REF_CYCLES (20),
      .CNT_W      (5)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .init_end   (init_end),
      .init_bus   (init_bus),
      .aref_bus   (aref_bus),
      .aref_end   (aref_end),
      .wr_bus     (wr_bus),
      .wr_end     (wr_end),
      .rd_bus     (rd_bus),
      .rd_end     (rd_end),
      .wr_trig    (wr_trig),
      .rd_trig    (rd_trig),
      .aref_en    (aref_en),
      .wr_en      (wr_en),
      .rd_en      (rd_en),
      .sdram_cmd  (sdram_cmd),
      .sdram_ba   (sdram_ba),
      .sdram_addr (sdram_addr),
      .busy       (busy),
      .aref_miss  (aref_miss)
   );

   // 10 ns clock
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      test_count++;
      assert (observed === expected) else begin
         fail_count++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic checkState(input string tag, input logic [3:0] grants, input logic [18:0] bus);
      checkOutput({tag, "/grants"}, {28'd0, aref_en, wr_en, rd_en, busy}, {28'd0, grants});
      checkOutput({tag, "/bus"}, {13'd0, sdram_cmd, sdram_ba, sdram_addr}, {13'd0, bus});
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Drive the selected one-cycle pulses, advance one edge, release them
   task automatic applyStimulus(input logic [4:0] p);
      {wr_trig, rd_trig, wr_end, rd_end, aref_end} = p;
      tick(1);
      {wr_trig, rd_trig, wr_end, rd_end, aref_end} = 5'b0;
   endtask

   // Reset, then complete init; returns in the first ARBIT cycle
   task automatic initSeq();
      rst_n = 1'b0;
      init_end = 1'b0;
      {wr_trig, rd_trig, wr_end, rd_end, aref_end} = 5'b0;
      tick(2);
      rst_n = 1'b1;
      tick(1);
      init_end = 1'b1;
      tick(1);
   endtask

   initial begin
      // Reset and init hand-off
      tick(2);
      checkState("reset", G_INIT, INIT_BUS);
      checkOutput("reset_miss", {31'd0, aref_miss}, 32'd0);
      rst_n = 1'b1;
      tick(1);
      checkState("init_wait", G_INIT, INIT_BUS);
      init_end = 1'b1;
      tick(1);
      checkState("init_done", G_ARBIT, NOP_BUS);

      // Single write burst, then the first periodic refresh
      applyStimulus(P_WTRIG);
      checkState("wr_pend", G_ARBIT, NOP_BUS);
      tick(1);
      checkState("wr_grant", G_WRITE, WR_BUS);
      tick(7);
      checkState("wr_hold", G_WRITE, WR_BUS);
      applyStimulus(P_WEND);
      checkState("wr_done", G_ARBIT, NOP_BUS);
      tick(10);
      checkState("aref_due", G_ARBIT, NOP_BUS);
      tick(1);
      checkState("aref_grant", G_AREF, AREF_BUS);
      applyStimulus(P_AEND);
      checkState("aref_done", G_ARBIT, NOP_BUS);

      // Simultaneous triggers, merged read triggers, ignored end pulse
      initSeq();
      applyStimulus(P_WTRIG | P_RTRIG);
      tick(1);
      checkState("both_wr_first", G_WRITE, WR_BUS);
      applyStimulus(P_RTRIG);
      tick(1);
      applyStimulus(P_RTRIG);
      tick(1);
      applyStimulus(P_RTRIG);
      tick(2);
      checkState("both_wr_hold", G_WRITE, WR_BUS);
      applyStimulus(P_WEND);
      checkState("both_wr_done", G_ARBIT, NOP_BUS);
      tick(1);
      checkState("both_rd_grant", G_READ, RD_BUS);
      applyStimulus(P_WEND);
      checkState("stray_end", G_READ, RD_BUS);
      applyStimulus(P_REND);
      checkState("both_rd_done", G_ARBIT, NOP_BUS);
      tick(1);
      checkState("one_read", G_ARBIT, NOP_BUS);

      // Refresh falls due during a long read, served before a pending write
      initSeq();
      applyStimulus(P_RTRIG);
      tick(1);
      checkState("lr_grant", G_READ, RD_BUS);
      tick(8);
      applyStimulus(P_WTRIG);
      tick(14);
      checkState("lr_no_preempt", G_READ, RD_BUS);
      tick(6);
      checkState("lr_last", G_READ, RD_BUS);
      applyStimulus(P_REND);
      checkState("lr_done", G_ARBIT, NOP_BUS);
      tick(1);
      checkState("lr_aref_first", G_AREF, AREF_BUS);
      applyStimulus(P_AEND);
      checkState("lr_aref_done", G_ARBIT, NOP_BUS);
      tick(1);
      checkState("lr_wr_after", G_WRITE, WR_BUS);
      checkOutput("lr_miss", {31'd0, aref_miss}, 32'd0);

      // Long write spans two terminal counts: miss flagged, one refresh
      initSeq();
      applyStimulus(P_WTRIG);
      tick(1);
      checkState("lw_grant", G_WRITE, WR_BUS);
      tick(37);
      checkOutput("lw_miss_before", {31'd0, aref_miss}, 32'd0);
      tick(1);
      checkOutput("lw_miss_set", {31'd0, aref_miss}, 32'd1);
      checkState("lw_hold", G_WRITE, WR_BUS);
      tick(6);
      applyStimulus(P_WEND);
      checkState("lw_done", G_ARBIT, NOP_BUS);
      tick(1);
      checkState("lw_aref", G_AREF, AREF_BUS);
      applyStimulus(P_AEND);
      checkState("lw_aref_done", G_ARBIT, NOP_BUS);
      tick(1);
      checkState("lw_one_aref", G_ARBIT, NOP_BUS);
      checkOutput("lw_miss_sticky", {31'd0, aref_miss}, 32'd1);

      // Asynchronous reset mid-write, trigger in INIT is dropped
      initSeq();
      applyStimulus(P_WTRIG);
      tick(3);
      checkState("ar_write", G_WRITE, WR_BUS);
      #2;
      rst_n = 1'b0;
      init_end = 1'b0;
      #1;
      checkState("ar_async", G_INIT, INIT_BUS);
      checkOutput("ar_miss", {31'd0, aref_miss}, 32'd0);
      tick(1);
      rst_n = 1'b1;
      tick(1);
      applyStimulus(P_WTRIG);
      checkState("ar_init_trig", G_INIT, INIT_BUS);
      init_end = 1'b1;
      tick(1);
      checkState("ar_arbit", G_ARBIT, NOP_BUS);
      tick(2);
      checkState("ar_trig_dropped", G_ARBIT, NOP_BUS);

      $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
      $finish;
   end

endmodule
